alu_arbiter: RTL and testbench

Shares one ALU (6-bit operands, 6-bit opcode, registered result) between two requesters.
- Per-requester command handshake (valid/ready) and response handshake (valid/ready).
- Round-robin arbitration; operands and opcode captured at grant.
- Drives the ALU operand/opcode inputs; captures the ALU result after a fixed latency; returns it to the winning requester.
- Sits between the input-loading logic and the ALU in the top level.

---
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with round-robin arbitration.
// Operands and opcode are captured into the ALU input registers at grant. The ALU
// result is captured after ALU_LAT+1 EXEC cycles and handed back to the winner.
// Optional macro ALU_ARB_OPCHECK_EN: opcodes outside the supported set bypass the
// ALU and are answered at once with o_rsp_err=1 and o_rsp_data=0.
module alu_arbiter #(
    parameter int NB_DATA = 6,
    parameter int NB_OP   = 6,
    parameter int ALU_LAT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           i_valid,
    input  logic [2*NB_DATA-1:0] i_A,
    input  logic [2*NB_DATA-1:0] i_B,
    input  logic [2*NB_OP-1:0]   i_OP,
    output logic [1:0]           o_ready,
    output logic [1:0]           o_rsp_valid,
    output logic [NB_DATA-1:0]   o_rsp_data,
    output logic                 o_rsp_err,
    input  logic [1:0]           i_rsp_ready,
    output logic [NB_DATA-1:0]   o_alu_A,
    output logic [NB_DATA-1:0]   o_alu_B,
    output logic [NB_OP-1:0]     o_alu_OP,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic                 o_busy
);

    localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state;
    state_t               next_state;
    logic                 ptr;
    logic                 winner;
    logic [CNT_W-1:0]     cnt;
    logic                 any_req;
    logic                 gnt_idx;
    logic                 op_ok;
    logic [NB_DATA-1:0]   sel_a;
    logic [NB_DATA-1:0]   sel_b;
    logic [NB_OP-1:0]     sel_op;

    // Pick the requester to grant and mux its command fields
    always_comb begin
        any_req = |i_valid;
        gnt_idx = (&i_valid) ? ptr : i_valid[1];
        sel_a   = gnt_idx ? i_A[2*NB_DATA-1:NB_DATA] : i_A[NB_DATA-1:0];
        sel_b   = gnt_idx ? i_B[2*NB_DATA-1:NB_DATA] : i_B[NB_DATA-1:0];
        sel_op  = gnt_idx ? i_OP[2*NB_OP-1:NB_OP]    : i_OP[NB_OP-1:0];
    end

`ifdef ALU_ARB_OPCHECK_EN
    function automatic logic op_supported(input logic [NB_OP-1:0] op);
        case (op)
            NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
            NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b100111),
            NB_OP'(6'b000011), NB_OP'(6'b000010): return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    assign op_ok = op_supported(sel_op);
`else
    assign op_ok = 1'b1;
`endif

    assign o_busy = (state != IDLE);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode and combinational grant
    always_comb begin
        next_state = state;
        o_ready    = 2'b00;
        case (state)
            IDLE: begin
                if (any_req) begin
                    o_ready    = gnt_idx ? 2'b10 : 2'b01;
                    next_state = op_ok ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (cnt == '0) next_state = RESP;
            end
            RESP: begin
                if (i_rsp_ready[winner]) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Command capture, EXEC countdown, response register and pointer update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr         <= 1'b0;
            winner      <= 1'b0;
            cnt         <= '0;
            o_alu_A     <= '0;
            o_alu_B     <= '0;
            o_alu_OP    <= '0;
            o_rsp_valid <= 2'b00;
            o_rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner <= gnt_idx;
                        if (op_ok) begin
                            o_alu_A  <= sel_a;
                            o_alu_B  <= sel_b;
                            o_alu_OP <= sel_op;
                            cnt      <= CNT_W'(ALU_LAT);
                        end else begin
                            o_rsp_data  <= '0;
                            o_rsp_valid <= gnt_idx ? 2'b10 : 2'b01;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        o_rsp_data  <= i_alu_result;
                        o_rsp_valid <= winner ? 2'b10 : 2'b01;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready[winner]) begin
                        o_rsp_valid <= 2'b00;
                        ptr         <= ~winner;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    logic rsp_err;

    // Error flag: set on an unsupported grant, cleared when the response is taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_err <= 1'b0;
        end else if (state == IDLE && any_req && !op_ok) begin
            rsp_err <= 1'b1;
        end else if (state == RESP && i_rsp_ready[winner]) begin
            rsp_err <= 1'b0;
        end
    end

    assign o_rsp_err = rsp_err;
`else
    assign o_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a registered ALU stub (ALU_LAT=1).
// Honours ALU_ARB_OPCHECK_EN when the macro is defined for the build.
module tb_alu_arbiter;

    localparam int NB_DATA = 6;
    localparam int NB_OP   = 6;
    localparam int ALU_LAT = 1;
`ifdef ALU_ARB_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    logic                 clock;
    logic                 reset;
    logic [1:0]           i_valid;
    logic [2*NB_DATA-1:0] i_A;
    logic [2*NB_DATA-1:0] i_B;
    logic [2*NB_OP-1:0]   i_OP;
    logic [1:0]           o_ready;
    logic [1:0]           o_rsp_valid;
    logic [NB_DATA-1:0]   o_rsp_data;
    logic                 o_rsp_err;
    logic [1:0]           i_rsp_ready;
    logic [NB_DATA-1:0]   o_alu_A;
    logic [NB_DATA-1:0]   o_alu_B;
    logic [NB_OP-1:0]     o_alu_OP;
    logic [NB_DATA-1:0]   alu_result;
    logic                 o_busy;

    int checks = 0;
    int passes = 0;

    logic [5:0] ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b100110, 6'b100111, 6'b000011, 6'b000010};

    alu_arbiter #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .ALU_LAT(ALU_LAT)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_valid      (i_valid),
        .i_A          (i_A),
        .i_B          (i_B),
        .i_OP         (i_OP),
        .o_ready      (o_ready),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_err    (o_rsp_err),
        .i_rsp_ready  (i_rsp_ready),
        .o_alu_A      (o_alu_A),
        .o_alu_B      (o_alu_B),
        .o_alu_OP     (o_alu_OP),
        .i_alu_result (alu_result),
        .o_busy       (o_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [5:0] alu_fn(input logic [5:0] a, input logic [5:0] b,
                                          input logic [5:0] op);
        logic signed [5:0] sa;
        sa = a;
        case (op)
            6'b100000: alu_fn = a + b;
            6'b100010: alu_fn = a - b;
            6'b100100: alu_fn = a & b;
            6'b100101: alu_fn = a | b;
            6'b100110: alu_fn = a ^ b;
            6'b100111: alu_fn = ~(a | b);
            6'b000011: alu_fn = $unsigned(sa >>> b);
            6'b000010: alu_fn = a >> b;
            default:   alu_fn = ~a;
        endcase
    endfunction

    function automatic bit is_supported(input logic [5:0] op);
        for (int i = 0; i < 8; i++) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Registered ALU stub: one cycle from stable inputs to result
    always_ff @(posedge clock) alu_result <= alu_fn(o_alu_A, o_alu_B, o_alu_OP);

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [5:0] a,
                           input logic [5:0] b, input logic [5:0] op);
        i_valid[k]                 = v;
        i_A[k*NB_DATA +: NB_DATA]  = a;
        i_B[k*NB_DATA +: NB_DATA]  = b;
        i_OP[k*NB_OP +: NB_OP]     = op;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        i_valid     = 2'b00;
        i_rsp_ready = 2'b00;
        #2;
        reset = 1'b0;
    endtask

    task automatic drain();
        i_valid     = 2'b00;
        i_rsp_ready = 2'b11;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!o_busy) break;
        end
    endtask

    task automatic test_single();
        tick();
        set_req(0, 1'b1, 6'd2, 6'd3, 6'b100000);
        i_rsp_ready = 2'b00;
        #1;
        checks++; if (o_ready !== 2'b01) $display("FAIL single_grant: got %b want 01", o_ready); else passes++;
        tick();
        checks++; if (o_ready !== 2'b00) $display("FAIL single_ready_drop: got %b want 00", o_ready); else passes++;
        checks++; if (o_busy !== 1'b1) $display("FAIL single_busy: got %b want 1", o_busy); else passes++;
        checks++; if (o_rsp_valid !== 2'b00) $display("FAIL single_rv_early1: got %b want 00", o_rsp_valid); else passes++;
        tick();
        checks++; if (o_rsp_valid !== 2'b00) $display("FAIL single_rv_early2: got %b want 00", o_rsp_valid); else passes++;
        checks++; if (o_ready !== 2'b00) $display("FAIL single_ready_exec: got %b want 00", o_ready); else passes++;
        tick();
        checks++; if (o_rsp_valid !== 2'b01) $display("FAIL single_rv: got %b want 01", o_rsp_valid); else passes++;
        checks++; if (o_rsp_data !== 6'd5) $display("FAIL single_data: got %0d want 5", o_rsp_data); else passes++;
        checks++; if (o_alu_A !== 6'd2 || o_alu_B !== 6'd3) $display("FAIL single_alu_ops: got %0d,%0d want 2,3", o_alu_A, o_alu_B); else passes++;
        i_valid     = 2'b00;
        i_rsp_ready = 2'b01;
        tick();
        checks++; if (o_rsp_valid !== 2'b00 || o_busy !== 1'b0) $display("FAIL single_accept: got rv=%b busy=%b want 00/0", o_rsp_valid, o_busy); else passes++;
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({o_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_alu_A, o_alu_B, o_alu_OP, o_busy} !== '0)
            $display("FAIL reset_outputs: got rdy=%b rv=%b d=%0d e=%b A=%0d B=%0d OP=%b busy=%b want all 0",
                     o_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_alu_A, o_alu_B, o_alu_OP, o_busy);
        else passes++;
        tick();
        reset   = 1'b0;
        i_valid = 2'b00;
        tick();
        checks++; if (o_ready !== 2'b00 || o_busy !== 1'b0) $display("FAIL reset_idle: got rdy=%b busy=%b want 00/0", o_ready, o_busy); else passes++;
        checks++; if (o_rsp_data !== '0 || o_alu_OP !== '0) $display("FAIL reset_hold: got d=%0d OP=%b want 0", o_rsp_data, o_alu_OP); else passes++;
    endtask

    task automatic test_alternate();
        int got_idx [4];
        int got_data[4];
        int got_cyc [4];
        int n = 0;
        tick();
        set_req(0, 1'b1, 6'd6, 6'd5, 6'b100010);
        set_req(1, 1'b1, 6'd5, 6'd5, 6'b100100);
        i_rsp_ready = 2'b11;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if ((o_rsp_valid & i_rsp_ready) != 2'b00) begin
                got_idx[n]  = int'(o_rsp_valid[1]);
                got_data[n] = int'(o_rsp_data);
                got_cyc[n]  = c;
                n++;
            end
        end
        i_valid = 2'b00;
        checks++; if (n != 4) $display("FAIL alt_count: got %0d want 4", n); else passes++;
        for (int i = 0; i < n; i++) begin
            checks++; if (got_idx[i] != i % 2) $display("FAIL alt_idx%0d: got %0d want %0d", i, got_idx[i], i % 2); else passes++;
            checks++; if (got_data[i] != ((i % 2) ? 5 : 1)) $display("FAIL alt_data%0d: got %0d want %0d", i, got_data[i], (i % 2) ? 5 : 1); else passes++;
            if (i > 0) begin
                checks++; if (got_cyc[i] - got_cyc[i-1] != ALU_LAT + 3) $display("FAIL alt_period%0d: got %0d want %0d", i, got_cyc[i] - got_cyc[i-1], ALU_LAT + 3); else passes++;
            end
        end
        drain();
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        set_req(0, 1'b1, 6'd5, 6'd2, 6'b100101);
        set_req(1, 1'b1, 6'd3, 6'd1, 6'b100110);
        i_rsp_ready = 2'b10;
        #1;
        checks++; if (o_ready !== 2'b01) $display("FAIL stall_grant0: got %b want 01", o_ready); else passes++;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (o_rsp_valid != 2'b00) break;
        end
        checks++; if (o_rsp_valid !== 2'b01) $display("FAIL stall_rv: got %b want 01", o_rsp_valid); else passes++;
        for (int c = 0; c < 5; c++) begin
            checks++; if (o_rsp_data !== 6'd7) $display("FAIL stall_data%0d: got %0d want 7", c, o_rsp_data); else passes++;
            checks++; if (o_rsp_valid !== 2'b01) $display("FAIL stall_hold%0d: got %b want 01", c, o_rsp_valid); else passes++;
            checks++; if (o_ready !== 2'b00) $display("FAIL stall_ready%0d: got %b want 00", c, o_ready); else passes++;
            tick();
        end
        i_rsp_ready = 2'b11;
        tick();
        checks++; if (o_ready !== 2'b10) $display("FAIL stall_grant1: got %b want 10", o_ready); else passes++;
        tick();
        i_valid = 2'b00;
        for (int c = 0; c < 10; c++) begin
            if (o_rsp_valid != 2'b00) break;
            tick();
        end
        checks++; if (o_rsp_valid !== 2'b10 || o_rsp_data !== 6'd2) $display("FAIL stall_rsp1: got rv=%b d=%0d want 10/2", o_rsp_valid, o_rsp_data); else passes++;
        drain();
    endtask

    task automatic test_reset_exec();
        do_reset();
        tick();
        set_req(0, 1'b0, 6'd0, 6'd0, 6'b100000);
        set_req(1, 1'b1, 6'd1, 6'd1, 6'b100000);
        i_rsp_ready = 2'b11;
        #1;
        checks++; if (o_ready !== 2'b10) $display("FAIL rexec_grant: got %b want 10", o_ready); else passes++;
        tick();
        checks++; if (o_busy !== 1'b1) $display("FAIL rexec_busy: got %b want 1", o_busy); else passes++;
        reset   = 1'b1;
        i_valid = 2'b00;
        #1;
        checks++; if (o_busy !== 1'b0 || o_rsp_valid !== 2'b00) $display("FAIL rexec_async: got busy=%b rv=%b want 0/00", o_busy, o_rsp_valid); else passes++;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if ({o_rsp_valid, o_busy} !== 3'b000) $display("FAIL rexec_quiet%0d: got rv=%b busy=%b want 00/0", c, o_rsp_valid, o_busy); else passes++;
        end
        set_req(0, 1'b1, 6'd1, 6'd2, 6'b100000);
        set_req(1, 1'b1, 6'd4, 6'd4, 6'b100000);
        #1;
        checks++; if (o_ready !== 2'b01) $display("FAIL rexec_ptr: got %b want 01", o_ready); else passes++;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (o_rsp_valid != 2'b00) break;
        end
        i_valid = 2'b00;
        checks++; if (o_rsp_valid !== 2'b01 || o_rsp_data !== 6'd3) $display("FAIL rexec_rsp: got rv=%b d=%0d want 01/3", o_rsp_valid, o_rsp_data); else passes++;
        drain();
    endtask

    task automatic test_badop();
        tick();
        set_req(0, 1'b0, 6'd0, 6'd0, 6'b100000);
        set_req(1, 1'b1, 6'd4, 6'd1, 6'b111111);
        i_rsp_ready = 2'b00;
        #1;
        checks++; if (o_ready !== 2'b10) $display("FAIL badop_grant: got %b want 10", o_ready); else passes++;
        tick();
        i_valid = 2'b00;
`ifdef ALU_ARB_OPCHECK_EN
        checks++; if (o_rsp_valid !== 2'b10) $display("FAIL badop_rv: got %b want 10", o_rsp_valid); else passes++;
        checks++; if (o_rsp_err !== 1'b1 || o_rsp_data !== '0) $display("FAIL badop_err: got e=%b d=%0d want 1/0", o_rsp_err, o_rsp_data); else passes++;
        checks++; if (o_alu_OP !== 6'b100000) $display("FAIL badop_aluop: got %b want 100000", o_alu_OP); else passes++;
        i_rsp_ready = 2'b10;
        tick();
        checks++; if (o_rsp_valid !== 2'b00 || o_rsp_err !== 1'b0) $display("FAIL badop_clear: got rv=%b e=%b want 00/0", o_rsp_valid, o_rsp_err); else passes++;
`else
        checks++; if (o_rsp_valid !== 2'b00) $display("FAIL badop_rv_early: got %b want 00", o_rsp_valid); else passes++;
        checks++; if (o_alu_OP !== 6'b111111) $display("FAIL badop_aluop: got %b want 111111", o_alu_OP); else passes++;
        tick();
        tick();
        checks++; if (o_rsp_valid !== 2'b10 || o_rsp_err !== 1'b0) $display("FAIL badop_rsp: got rv=%b e=%b want 10/0", o_rsp_valid, o_rsp_err); else passes++;
        checks++; if (o_rsp_data !== 6'b111011) $display("FAIL badop_data: got %b want 111011", o_rsp_data); else passes++;
        i_rsp_ready = 2'b10;
        tick();
        checks++; if (o_rsp_valid !== 2'b00) $display("FAIL badop_accept: got %b want 00", o_rsp_valid); else passes++;
`endif
        drain();
    endtask

    task automatic test_random();
        bit         m_busy = 1'b0;
        int         m_win  = 0;
        int         m_ptr  = 0;
        int         m_since = 0;
        int         m_lat  = 0;
        logic [5:0] m_data = '0;
        logic       m_err  = 1'b0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            int         k;
            bit         resp;
            logic [1:0] exp_rdy;
            logic [1:0] exp_rv;
            tick();
            for (int r = 0; r < 2; r++) begin
                logic [5:0] op;
                if ($urandom_range(0, 4) == 0) op = 6'($urandom);
                else                           op = ops[$urandom_range(0, 7)];
                set_req(r, 1'($urandom), 6'($urandom), 6'($urandom), op);
            end
            i_rsp_ready = 2'($urandom);
            #1;
            k       = (i_valid == 2'b11) ? m_ptr : int'(i_valid[1]);
            exp_rdy = (!m_busy && i_valid != 2'b00) ? 2'(1 << k) : 2'b00;
            resp    = m_busy && (m_since >= m_lat);
            exp_rv  = resp ? 2'(1 << m_win) : 2'b00;
            checks++; if (o_ready !== exp_rdy) $display("FAIL rnd_ready c%0d: got %b want %b", c, o_ready, exp_rdy); else passes++;
            checks++; if (o_busy !== m_busy) $display("FAIL rnd_busy c%0d: got %b want %b", c, o_busy, m_busy); else passes++;
            checks++; if (o_rsp_valid !== exp_rv) $display("FAIL rnd_rv c%0d: got %b want %b", c, o_rsp_valid, exp_rv); else passes++;
            checks++; if (o_rsp_err !== (resp ? m_err : 1'b0)) $display("FAIL rnd_err c%0d: got %b want %b", c, o_rsp_err, resp ? m_err : 1'b0); else passes++;
            if (resp) begin
                checks++; if (o_rsp_data !== m_data) $display("FAIL rnd_data c%0d: got %0d want %0d", c, o_rsp_data, m_data); else passes++;
            end
            if (!m_busy && i_valid != 2'b00) begin
                logic [5:0] a;
                logic [5:0] b;
                logic [5:0] op;
                a       = i_A[k*NB_DATA +: NB_DATA];
                b       = i_B[k*NB_DATA +: NB_DATA];
                op      = i_OP[k*NB_OP +: NB_OP];
                m_busy  = 1'b1;
                m_win   = k;
                m_since = 0;
                m_err   = OPCHECK && !is_supported(op);
                m_lat   = m_err ? 0 : ALU_LAT + 1;
                m_data  = m_err ? 6'd0 : alu_fn(a, b, op);
            end else if (m_busy) begin
                if (resp) begin
                    if (i_rsp_ready[m_win]) begin
                        m_busy = 1'b0;
                        m_ptr  = 1 - m_win;
                    end
                end else begin
                    m_since++;
                end
            end
        end
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        reset       = 1'b1;
        i_valid     = 2'b00;
        i_A         = '0;
        i_B         = '0;
        i_OP        = '0;
        i_rsp_ready = 2'b00;
        #12;
        reset = 1'b0;
        test_single();
        test_reset();
        test_alternate();
        test_stall();
        test_reset_exec();
        test_badop();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
